// File: rtl/stream_checksum_multi.sv
// RFC 1071 ones'-complement checksum over an Avalon-ST packet stream of any 16-bit-multiple width.
// Define STREAM_CHECKSUM_LENGTH_EN to add the per-packet byte count output checksum_length.
module stream_checksum_multi #(
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = (DATA_WIDTH / 8 > 2) ? $clog2(DATA_WIDTH / 8) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  stream_in_data,
  input  logic                   stream_in_valid,
  output logic                   stream_in_ready,
  input  logic                   stream_in_startofpacket,
  input  logic                   stream_in_endofpacket,
  input  logic [EMPTY_WIDTH-1:0] stream_in_empty,
  output logic [15:0]            checksum_data,
  output logic                   checksum_valid,
  input  logic                   checksum_ready,
  output logic                   checksum_error,
`ifdef STREAM_CHECKSUM_LENGTH_EN
  output logic [15:0]            checksum_length,
`endif
  output logic [15:0]            framing_errors
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned NWORDS = DATA_WIDTH / 16;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t                state, state_next;
  logic [15:0]           acc, acc_next, beat_sum, res_sum;
  logic                  res_load, res_err, accept;
  logic [1:0]            fe_inc;
  logic [16:0]           fe_sum;
  logic [DATA_WIDTH-1:0] masked;
  logic [31:0]           empty_ext;

  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  assign stream_in_ready = !checksum_valid || checksum_ready;
  assign accept          = stream_in_valid && stream_in_ready;
  assign empty_ext       = 32'(stream_in_empty);
  assign fe_sum          = {1'b0, framing_errors} + 17'(fe_inc);

  always_comb begin
    masked = stream_in_data;
    if (stream_in_endofpacket) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (i < empty_ext) masked[i*8 +: 8] = '0;
      end
    end
    beat_sum = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      beat_sum = ones_add(beat_sum, masked[i*16 +: 16]);
    end
  end

`ifdef STREAM_CHECKSUM_LENGTH_EN
  logic [15:0] len, len_next, res_len, beat_bytes;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? '1 : s[15:0];
  endfunction

  always_comb begin
    beat_bytes = 16'(NBYTES);
    if (stream_in_endofpacket)
      beat_bytes = (empty_ext >= NBYTES) ? '0 : 16'(NBYTES - empty_ext);
  end
`endif

  always_comb begin
    state_next = state;
    acc_next   = acc;
    res_load   = 1'b0;
    res_sum    = acc;
    res_err    = 1'b0;
    fe_inc     = 2'd0;
`ifdef STREAM_CHECKSUM_LENGTH_EN
    len_next   = len;
    res_len    = len;
`endif
    if (accept) begin
      case (state)
        IDLE: begin
          if (stream_in_startofpacket) begin
            acc_next = beat_sum;
`ifdef STREAM_CHECKSUM_LENGTH_EN
            len_next = beat_bytes;
            res_len  = beat_bytes;
`endif
            res_sum = beat_sum;
            if (stream_in_endofpacket) res_load = 1'b1;
            else                       state_next = IN_PKT;
          end else begin
            fe_inc = 2'd1;
          end
        end
        IN_PKT: begin
          if (stream_in_startofpacket) begin
            // Truncated packet reports what it had; an SOP+EOP interrupter is dropped outright.
            res_load = 1'b1;
            res_err  = 1'b1;
            acc_next = beat_sum;
`ifdef STREAM_CHECKSUM_LENGTH_EN
            len_next = beat_bytes;
`endif
            if (stream_in_endofpacket) begin
              fe_inc     = 2'd2;
              state_next = IDLE;
            end else begin
              fe_inc = 2'd1;
            end
          end else begin
            acc_next = ones_add(acc, beat_sum);
            res_sum  = acc_next;
`ifdef STREAM_CHECKSUM_LENGTH_EN
            len_next = sat_add(len, beat_bytes);
            res_len  = len_next;
`endif
            if (stream_in_endofpacket) begin
              res_load   = 1'b1;
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc            <= '0;
      checksum_data  <= '0;
      checksum_valid <= 1'b0;
      checksum_error <= 1'b0;
      framing_errors <= '0;
`ifdef STREAM_CHECKSUM_LENGTH_EN
      len             <= '0;
      checksum_length <= '0;
`endif
    end else begin
      acc            <= acc_next;
      framing_errors <= fe_sum[16] ? '1 : fe_sum[15:0];
`ifdef STREAM_CHECKSUM_LENGTH_EN
      len <= len_next;
`endif
      if (res_load) begin
        checksum_valid <= 1'b1;
        checksum_data  <= ~res_sum;
        checksum_error <= res_err;
`ifdef STREAM_CHECKSUM_LENGTH_EN
        checksum_length <= res_len;
`endif
      end else if (checksum_ready) begin
        checksum_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_checksum_multi.sv
// Self-checking bench for stream_checksum_multi: 32-bit and 64-bit instances against a byte-level RFC 1071 model.
module tb_stream_checksum_multi;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] in_data;
  logic        in_valid, in_sop, in_eop, in_ready;
  logic [1:0]  in_empty;
  logic [15:0] cs_data, fe;
  logic        cs_valid, cs_ready, cs_err;

  logic [63:0] w_data;
  logic        w_valid, w_sop, w_eop, w_ready;
  logic [2:0]  w_empty;
  logic [15:0] w_cs_data, w_fe;
  logic        w_cs_valid, w_cs_ready, w_cs_err;

`ifdef STREAM_CHECKSUM_LENGTH_EN
  logic [15:0] cs_len, w_cs_len;
`endif

  int checks = 0;
  int passes = 0;

  stream_checksum_multi #(.DATA_WIDTH(32), .EMPTY_WIDTH(2)) dut (
    .clk(clk), .reset(reset),
    .stream_in_data(in_data), .stream_in_valid(in_valid), .stream_in_ready(in_ready),
    .stream_in_startofpacket(in_sop), .stream_in_endofpacket(in_eop), .stream_in_empty(in_empty),
    .checksum_data(cs_data), .checksum_valid(cs_valid), .checksum_ready(cs_ready),
    .checksum_error(cs_err),
`ifdef STREAM_CHECKSUM_LENGTH_EN
    .checksum_length(cs_len),
`endif
    .framing_errors(fe)
  );

  stream_checksum_multi #(.DATA_WIDTH(64), .EMPTY_WIDTH(3)) dut64 (
    .clk(clk), .reset(reset),
    .stream_in_data(w_data), .stream_in_valid(w_valid), .stream_in_ready(w_ready),
    .stream_in_startofpacket(w_sop), .stream_in_endofpacket(w_eop), .stream_in_empty(w_empty),
    .checksum_data(w_cs_data), .checksum_valid(w_cs_valid), .checksum_ready(w_cs_ready),
    .checksum_error(w_cs_err),
`ifdef STREAM_CHECKSUM_LENGTH_EN
    .checksum_length(w_cs_len),
`endif
    .framing_errors(w_fe)
  );

  // Reference: big-endian 16-bit words, odd tail padded with zero, folded sum, inverted.
  function automatic logic [15:0] ref_csum(input logic [7:0] b[$]);
    int unsigned s = 0;
    logic [15:0] w;
    for (int i = 0; i < b.size(); i += 2) begin
      w = {b[i], (i + 1 < b.size()) ? b[i+1] : 8'h00};
      s += 32'(w);
    end
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return ~16'(s);
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp);
    int n = 0;
    @(negedge clk);
    in_data = d; in_sop = s; in_eop = e; in_empty = emp; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) $display("FAIL beat_accept_timeout ready=%b required 1", in_ready);
    else passes++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] b[$]);
    int nb;
    logic [31:0] d;
    nb = (b.size() + 3) / 4;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 4; j++)
        d[31-8*j -: 8] = (k*4 + j < b.size()) ? b[k*4+j] : 8'($urandom);
      send_beat(d, k == 0, k == nb - 1, (k == nb - 1) ? 2'(nb*4 - b.size()) : 2'd0);
    end
  endtask

  task automatic send_wide(input logic [63:0] d, input logic s, input logic e, input logic [2:0] emp);
    @(negedge clk);
    w_data = d; w_sop = s; w_eop = e; w_empty = emp; w_valid = 1'b1;
    @(posedge clk);
    #1 w_valid = 1'b0;
  endtask

  task automatic drain();
    cs_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 0; in_sop = 0; in_eop = 0; in_empty = 0; in_data = '0; cs_ready = 1'b1;
    w_valid = 0; w_sop = 0; w_eop = 0; w_empty = 0; w_data = '0; w_cs_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    checks++;
    if ({cs_valid, cs_err, cs_data, fe, in_ready} !== {1'b0, 1'b0, 16'h0, 16'h0, 1'b1})
      $display("FAIL reset_state got v=%b e=%b d=%h fe=%h rdy=%b required 0 0 0000 0000 1",
               cs_valid, cs_err, cs_data, fe, in_ready);
    else passes++;
    checks++;
    if ({w_cs_valid, w_cs_err, w_cs_data, w_fe} !== 34'h0)
      $display("FAIL reset_state_wide got v=%b e=%b d=%h fe=%h required all zero",
               w_cs_valid, w_cs_err, w_cs_data, w_fe);
    else passes++;
  endtask

  task automatic test_vectors();
    drain();
    send_beat(32'h0001F203, 1, 0, 0);
    send_beat(32'hF4F5F6F7, 0, 1, 0);
    checks++;
    if ({cs_valid, cs_err, cs_data} !== {1'b1, 1'b0, 16'h220D})
      $display("FAIL vector_two_beat got v=%b e=%b d=%h required 1 0 220d", cs_valid, cs_err, cs_data);
    else passes++;
`ifdef STREAM_CHECKSUM_LENGTH_EN
    checks++;
    if (cs_len !== 16'd8) $display("FAIL vector_two_beat_len got %0d required 8", cs_len);
    else passes++;
`endif
    send_beat(32'hABCDEF00, 1, 1, 2'd1);
    checks++;
    if ({cs_valid, cs_err, cs_data} !== {1'b1, 1'b0, 16'h6531})
      $display("FAIL vector_empty1 got v=%b e=%b d=%h required 1 0 6531", cs_valid, cs_err, cs_data);
    else passes++;
`ifdef STREAM_CHECKSUM_LENGTH_EN
    checks++;
    if (cs_len !== 16'd3) $display("FAIL vector_empty1_len got %0d required 3", cs_len);
    else passes++;
`endif
  endtask

  task automatic test_random();
    logic [7:0]  q[$];
    logic [15:0] exp;
    drain();
    for (int p = 0; p < 40; p++) begin
      q = {};
      for (int i = 0; i < int'($urandom_range(1, 23)); i++) q.push_back(8'($urandom));
      exp = ref_csum(q);
      send_packet(q);
      checks++;
      if ({cs_valid, cs_err, cs_data} !== {1'b1, 1'b0, exp})
        $display("FAIL random_pkt%0d len=%0d got v=%b e=%b d=%h required 1 0 %h",
                 p, q.size(), cs_valid, cs_err, cs_data, exp);
      else passes++;
`ifdef STREAM_CHECKSUM_LENGTH_EN
      checks++;
      if (cs_len !== 16'(q.size())) $display("FAIL random_len%0d got %0d required %0d", p, cs_len, q.size());
      else passes++;
`endif
    end
  endtask

  task automatic test_back_to_back_hold();
    logic [31:0] a, b;
    logic [7:0]  qa[$], qb[$];
    drain();
    a = $urandom; b = $urandom;
    qa = {a[31:24], a[23:16], a[15:8], a[7:0]};
    qb = {b[31:24], b[23:16], b[15:8], b[7:0]};
    @(negedge clk) cs_ready = 1'b0;
    send_beat(a, 1, 1, 0);
    @(negedge clk);
    in_data = b; in_sop = 1; in_eop = 1; in_empty = 0; in_valid = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, cs_valid, cs_data} !== {1'b0, 1'b1, ref_csum(qa)})
      $display("FAIL hold_stall got rdy=%b v=%b d=%h required 0 1 %h", in_ready, cs_valid, cs_data, ref_csum(qa));
    else passes++;
    cs_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    checks++;
    if ({cs_valid, cs_err, cs_data} !== {1'b1, 1'b0, ref_csum(qb)})
      $display("FAIL hold_release got v=%b e=%b d=%h required 1 0 %h", cs_valid, cs_err, cs_data, ref_csum(qb));
    else passes++;
  endtask

  task automatic test_framing();
    logic [15:0] fe0;
    drain();
    fe0 = fe;
    send_beat(32'h00010002, 1, 0, 0);
    send_beat(32'h11112222, 1, 0, 0);
    checks++;
    if ({cs_valid, cs_err, cs_data, fe} !== {1'b1, 1'b1, 16'hFFFC, 16'(fe0 + 1)})
      $display("FAIL truncate got v=%b e=%b d=%h fe=%h required 1 1 fffc %h", cs_valid, cs_err, cs_data, fe, 16'(fe0 + 1));
    else passes++;
`ifdef STREAM_CHECKSUM_LENGTH_EN
    checks++;
    if (cs_len !== 16'd4) $display("FAIL truncate_len got %0d required 4", cs_len);
    else passes++;
`endif
    send_beat(32'h33334444, 0, 1, 0);
    checks++;
    if ({cs_valid, cs_err, cs_data} !== {1'b1, 1'b0, ref_csum('{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44})})
      $display("FAIL after_truncate got v=%b e=%b d=%h", cs_valid, cs_err, cs_data);
    else passes++;
    send_beat(32'h12345678, 1, 0, 0);
    send_beat(32'h9ABCDEF0, 1, 1, 0);
    checks++;
    if ({cs_valid, cs_err, cs_data, fe} !== {1'b1, 1'b1, ref_csum('{8'h12, 8'h34, 8'h56, 8'h78}), 16'(fe0 + 3)})
      $display("FAIL truncate_sop_eop got v=%b e=%b d=%h fe=%h required fe %h", cs_valid, cs_err, cs_data, fe, 16'(fe0 + 3));
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (cs_valid !== 1'b0) $display("FAIL dropped_pkt_result got v=%b required 0", cs_valid);
    else passes++;
    send_beat(32'h5555AAAA, 0, 1, 0);
    checks++;
    if ({cs_valid, fe} !== {1'b0, 16'(fe0 + 4)})
      $display("FAIL idle_no_sop got v=%b fe=%h required 0 %h", cs_valid, fe, 16'(fe0 + 4));
    else passes++;
  endtask

  task automatic test_reset_midpacket();
    logic [7:0] q[$];
    drain();
    send_beat(32'hDEADBEEF, 1, 0, 0);
    @(negedge clk) cs_ready = 1'b0;
    send_beat(32'hCAFEF00D, 1, 0, 0);
    @(negedge clk) reset = 1'b1;
    #1;
    checks++;
    if ({cs_valid, cs_err, cs_data, fe} !== {1'b0, 1'b0, 16'h0, 16'h0})
      $display("FAIL async_reset got v=%b e=%b d=%h fe=%h required all zero", cs_valid, cs_err, cs_data, fe);
    else passes++;
    @(negedge clk) reset = 1'b0;
    cs_ready = 1'b1;
    send_beat(32'h0000FFFF, 0, 1, 0);
    checks++;
    if ({cs_valid, fe} !== {1'b0, 16'h1})
      $display("FAIL reset_to_idle got v=%b fe=%h required 0 0001", cs_valid, fe);
    else passes++;
    q = {8'h45, 8'h00, 8'h00, 8'h1C, 8'h9A, 8'hBC, 8'h40};
    send_packet(q);
    checks++;
    if ({cs_valid, cs_err, cs_data} !== {1'b1, 1'b0, ref_csum(q)})
      $display("FAIL post_reset_pkt got v=%b e=%b d=%h required 1 0 %h", cs_valid, cs_err, cs_data, ref_csum(q));
    else passes++;
  endtask

  task automatic test_wide();
    logic [63:0] d;
    logic [7:0]  q[$];
    send_wide('0, 1, 0, 0);
    send_wide('0, 0, 0, 0);
    send_wide('0, 0, 1, 0);
    checks++;
    if ({w_cs_valid, w_cs_err, w_cs_data} !== {1'b1, 1'b0, 16'hFFFF})
      $display("FAIL wide_zero got v=%b e=%b d=%h required 1 0 ffff", w_cs_valid, w_cs_err, w_cs_data);
    else passes++;
    send_wide('1, 1, 0, 0);
    send_wide('1, 0, 1, 0);
    checks++;
    if ({w_cs_valid, w_cs_err, w_cs_data} !== {1'b1, 1'b0, 16'h0000})
      $display("FAIL wide_ones got v=%b e=%b d=%h required 1 0 0000", w_cs_valid, w_cs_err, w_cs_data);
    else passes++;
    d = {$urandom, $urandom};
    q = {d[63:56], d[55:48], d[47:40], d[39:32], d[31:24]};
    send_wide(d, 1, 1, 3'd3);
    checks++;
    if ({w_cs_valid, w_cs_data} !== {1'b1, ref_csum(q)})
      $display("FAIL wide_empty3 got v=%b d=%h required 1 %h", w_cs_valid, w_cs_data, ref_csum(q));
    else passes++;
  endtask

  task automatic test_fe_saturation();
    @(negedge clk);
    w_sop = 0; w_eop = 0; w_valid = 1;
    repeat (65540) @(posedge clk);
    #1 w_valid = 0;
    checks++;
    if ({w_cs_valid, w_fe} !== {1'b0, 16'hFFFF})
      $display("FAIL fe_saturate got v=%b fe=%h required 0 ffff", w_cs_valid, w_fe);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back_hold();
    test_framing();
    test_reset_midpacket();
    test_wide();
    test_fe_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
